// File: rtl/status_register_unit.sv
`default_nettype none
// ============================================================================
//  Module      : status_register_unit
//  Description : Architectural NZCV status register with a delayed commit
//                pipeline and an ID-stage flag hazard detector.
//
//                Flag-setting instructions in EX push their ALU flags into
//                a shift pipeline of COMMIT_DELAY slots. Flags reach the
//                architectural register when they shift out of the last slot.
//                Status bit order is {Z, C, N, V}, which matches the
//                condition checker.
//
//  Ports       : clk          - system clock, rising edge
//                rst          - synchronous reset, active-low
//                ex_valid     - EX stage holds a live instruction
//                ex_s_bit     - EX instruction sets flags
//                ex_stall     - EX frozen; instruction re-presented next cycle
//                ex_flush     - EX instruction squashed this cycle
//                alu_flags    - {Z,C,N,V} from the ALU for the EX instruction
//                id_cond_used - ID instruction has a real (non-always) condition
//                status_out   - {Z,C,N,V} presented to the condition checker
//                flags_hazard - stall request for ID/IF
//                pending_cnt  - number of valid commit slots
//
//  Options     : STATUS_FLAG_FORWARD_EN - when defined, status_out forwards
//                the newest in-flight flags and flags_hazard is tied to 0.
//
//  Revision    : 1.0 - initial release
// ============================================================================

module status_register_unit #(
    parameter int COMMIT_DELAY = 2,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_s_bit,
    input  logic             ex_stall,
    input  logic             ex_flush,
    input  logic [3:0]       alu_flags,
    input  logic             id_cond_used,
    output logic [3:0]       status_out,
    output logic             flags_hazard,
    output logic [CNT_W-1:0] pending_cnt
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if ((COMMIT_DELAY < 1) || (COMMIT_DELAY > 4)) begin : g_bad_commit_delay
        $error("status_register_unit: COMMIT_DELAY must be in 1..4");
    end

    if ((1 << CNT_W) < (COMMIT_DELAY + 1)) begin : g_bad_cnt_w
        $error("status_register_unit: CNT_W too narrow for COMMIT_DELAY");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [3:0]              r_sr;
    logic [COMMIT_DELAY-1:0] r_slot_valid;
    logic [3:0]              r_slot_flags [COMMIT_DELAY];
    logic [CNT_W-1:0]        r_pending_cnt;

    logic                    w_cap;
    logic                    w_cap_pending;
    logic [COMMIT_DELAY-1:0] w_slot_valid_next;
    logic [CNT_W-1:0]        w_pending_next;
    logic [3:0]              w_status;
    logic                    w_hazard;

    // A flush kills the EX entry even if it is also stalled.
    assign w_cap         = ex_valid & ex_s_bit & ~ex_stall & ~ex_flush;
    // A stalled S instruction will still write later, so it already counts
    // as in flight for hazard and forwarding purposes.
    assign w_cap_pending = ex_valid & ex_s_bit & ~ex_flush;

    // Valid bits after the next shift; slots always advance.
    always_comb begin
        w_slot_valid_next    = '0;
        w_slot_valid_next[0] = w_cap;
        for (int i = 1; i < COMMIT_DELAY; i++) begin
            w_slot_valid_next[i] = r_slot_valid[i-1];
        end
    end

    // pending_cnt is registered, so count the post-edge valid bits.
    always_comb begin
        w_pending_next = '0;
        for (int i = 0; i < COMMIT_DELAY; i++) begin
            w_pending_next = w_pending_next + CNT_W'(w_slot_valid_next[i]);
        end
    end

    // Control state: reset discards every in-flight flag write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sr          <= 4'b0000;
            r_slot_valid  <= '0;
            r_pending_cnt <= '0;
        end else begin
            r_slot_valid  <= w_slot_valid_next;
            r_pending_cnt <= w_pending_next;
            if (r_slot_valid[COMMIT_DELAY-1]) begin
                r_sr <= r_slot_flags[COMMIT_DELAY-1];
            end
        end
    end

    // Slot payloads carry no reset; their meaning is gated by the valid bits.
    always_ff @(posedge clk) begin
        r_slot_flags[0] <= alu_flags;
        for (int i = 1; i < COMMIT_DELAY; i++) begin
            r_slot_flags[i] <= r_slot_flags[i-1];
        end
    end

    // ------------------------------------------------------------------------
    // Output selection
    // ------------------------------------------------------------------------
`ifdef STATUS_FLAG_FORWARD_EN
    logic [3:0] w_fwd_flags;

    // Newest flags win: EX first, then the youngest (lowest-index) slot,
    // then the architectural value. Scan oldest to youngest so the
    // youngest valid slot overwrites.
    always_comb begin
        w_fwd_flags = r_sr;
        for (int i = COMMIT_DELAY - 1; i >= 0; i--) begin
            if (r_slot_valid[i]) begin
                w_fwd_flags = r_slot_flags[i];
            end
        end
        if (w_cap_pending) begin
            w_fwd_flags = alu_flags;
        end
    end

    assign w_status = w_fwd_flags;
    assign w_hazard = 1'b0;
`else
    assign w_status = r_sr;
    assign w_hazard = id_cond_used & (w_cap_pending | (|r_slot_valid));
`endif

    // Outputs read as zero for as long as reset is asserted, including
    // the cycle before the first reset edge.
    assign status_out   = rst ? w_status      : 4'b0000;
    assign flags_hazard = rst ? w_hazard      : 1'b0;
    assign pending_cnt  = rst ? r_pending_cnt : '0;

endmodule

`default_nettype wire

// File: tb/tb_status_register_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_status_register_unit
//  Description : Directed, table-driven bench for status_register_unit with
//                COMMIT_DELAY=2. Each vector drives inputs after a falling
//                edge, checks outputs mid-low-phase, then the rising edge
//                applies the vector.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_status_register_unit;

    localparam int COMMIT_DELAY = 2;
    localparam int CNT_W        = 3;

    logic             clk;
    logic             rst;
    logic             ex_valid;
    logic             ex_s_bit;
    logic             ex_stall;
    logic             ex_flush;
    logic [3:0]       alu_flags;
    logic             id_cond_used;
    logic [3:0]       status_out;
    logic             flags_hazard;
    logic [CNT_W-1:0] pending_cnt;

    int n_vec;
    int n_miss;

    status_register_unit #(
        .COMMIT_DELAY (COMMIT_DELAY),
        .CNT_W        (CNT_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_s_bit     (ex_s_bit),
        .ex_stall     (ex_stall),
        .ex_flush     (ex_flush),
        .alu_flags    (alu_flags),
        .id_cond_used (id_cond_used),
        .status_out   (status_out),
        .flags_hazard (flags_hazard),
        .pending_cnt  (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             valid;
        logic             s_bit;
        logic             stall;
        logic             flush;
        logic [3:0]       flags;
        logic             cond_used;
        logic [3:0]       exp_status;
        logic             exp_hazard;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic s,
                                input logic st, input logic fl,
                                input logic [3:0] f, input logic cu,
                                input logic [3:0] es, input logic eh,
                                input logic [CNT_W-1:0] ec);
        vec_t x;
        x.rst = r; x.valid = v; x.s_bit = s; x.stall = st; x.flush = fl;
        x.flags = f; x.cond_used = cu;
        x.exp_status = es; x.exp_hazard = eh; x.exp_cnt = ec;
        return x;
    endfunction

    // Drive one vector, check pre-edge outputs, leave the edge to apply it.
    task automatic apply(input vec_t x, input string name);
        @(negedge clk);
        rst          = x.rst;
        ex_valid     = x.valid;
        ex_s_bit     = x.s_bit;
        ex_stall     = x.stall;
        ex_flush     = x.flush;
        alu_flags    = x.flags;
        id_cond_used = x.cond_used;
        #2;
        n_vec++;
        if (status_out !== x.exp_status) begin
            n_miss++;
            $display("FAIL %s status_out: got %b expected %b", name, status_out, x.exp_status);
        end
        if (flags_hazard !== x.exp_hazard) begin
            n_miss++;
            $display("FAIL %s flags_hazard: got %b expected %b", name, flags_hazard, x.exp_hazard);
        end
        if (pending_cnt !== x.exp_cnt) begin
            n_miss++;
            $display("FAIL %s pending_cnt: got %0d expected %0d", name, pending_cnt, x.exp_cnt);
        end
    endtask

`ifndef STATUS_FLAG_FORWARD_EN
    vec_t vecs [30];
`endif

    initial begin
        n_vec        = 0;
        n_miss       = 0;
        rst          = 1'b0;
        ex_valid     = 1'b0;
        ex_s_bit     = 1'b0;
        ex_stall     = 1'b0;
        ex_flush     = 1'b0;
        alu_flags    = 4'b0000;
        id_cond_used = 1'b0;

`ifndef STATUS_FLAG_FORWARD_EN
        //              rst v  s  stl fl  flags    cu   status   hz   cnt
        // Reset held with a would-be capture present.
        vecs[0]  = mk(0, 1, 1, 0, 0, 4'b1000, 1, 4'b0000, 0, 3'd0);
        vecs[1]  = mk(0, 1, 1, 0, 0, 4'b1000, 1, 4'b0000, 0, 3'd0);
        vecs[2]  = mk(0, 1, 1, 0, 0, 4'b1000, 1, 4'b0000, 0, 3'd0);
        vecs[3]  = mk(1, 0, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 3'd0);
        vecs[4]  = mk(1, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 3'd0);
        // Single capture of 0110: hazard for EX cycle + 2, commit after 2 edges.
        vecs[5]  = mk(1, 1, 1, 0, 0, 4'b0110, 1, 4'b0000, 1, 3'd0);
        vecs[6]  = mk(1, 0, 0, 0, 0, 4'b0000, 1, 4'b0000, 1, 3'd1);
        vecs[7]  = mk(1, 0, 0, 0, 0, 4'b0000, 1, 4'b0000, 1, 3'd1);
        vecs[8]  = mk(1, 0, 0, 0, 0, 4'b0000, 1, 4'b0110, 0, 3'd0);
        // Back-to-back 0001 then 1100, unconditional ID (no hazard).
        vecs[9]  = mk(1, 1, 1, 0, 0, 4'b0001, 0, 4'b0110, 0, 3'd0);
        vecs[10] = mk(1, 1, 1, 0, 0, 4'b1100, 0, 4'b0110, 0, 3'd1);
        vecs[11] = mk(1, 0, 0, 0, 0, 4'b0000, 0, 4'b0110, 0, 3'd2);
        vecs[12] = mk(1, 0, 0, 0, 0, 4'b0000, 0, 4'b0001, 0, 3'd1);
        vecs[13] = mk(1, 0, 0, 0, 0, 4'b0000, 0, 4'b1100, 0, 3'd0);
        // Flushed S instruction: no capture, no hazard.
        vecs[14] = mk(1, 1, 1, 0, 1, 4'b1111, 1, 4'b1100, 0, 3'd0);
        vecs[15] = mk(1, 0, 0, 0, 0, 4'b0000, 1, 4'b1100, 0, 3'd0);
        // Stalled S instruction: hazard, capture only once stall drops.
        vecs[16] = mk(1, 1, 1, 1, 0, 4'b1010, 1, 4'b1100, 1, 3'd0);
        vecs[17] = mk(1, 1, 1, 1, 0, 4'b1010, 1, 4'b1100, 1, 3'd0);
        vecs[18] = mk(1, 1, 1, 0, 0, 4'b1010, 1, 4'b1100, 1, 3'd0);
        vecs[19] = mk(1, 0, 0, 0, 0, 4'b0000, 1, 4'b1100, 1, 3'd1);
        vecs[20] = mk(1, 0, 0, 0, 0, 4'b0000, 1, 4'b1100, 1, 3'd1);
        vecs[21] = mk(1, 0, 0, 0, 0, 4'b0000, 1, 4'b1010, 0, 3'd0);
        // Stall and flush together: flush wins.
        vecs[22] = mk(1, 1, 1, 1, 1, 4'b0011, 1, 4'b1010, 0, 3'd0);
        vecs[23] = mk(1, 0, 0, 0, 0, 4'b0000, 0, 4'b1010, 0, 3'd0);
        // Two slots in flight, then reset discards both.
        vecs[24] = mk(1, 1, 1, 0, 0, 4'b0010, 0, 4'b1010, 0, 3'd0);
        vecs[25] = mk(1, 1, 1, 0, 0, 4'b0100, 0, 4'b1010, 0, 3'd1);
        vecs[26] = mk(0, 0, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 3'd0);
        vecs[27] = mk(1, 0, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 3'd0);
        vecs[28] = mk(1, 0, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 3'd0);
        vecs[29] = mk(1, 0, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 3'd0);

        for (int i = 0; i < 30; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Four consecutive captures: pipeline stays full, commits in order.
        apply(mk(1, 1, 1, 0, 0, 4'b0011, 1, 4'b0000, 1, 3'd0), "burst0");
        apply(mk(1, 1, 1, 0, 0, 4'b0101, 1, 4'b0000, 1, 3'd1), "burst1");
        apply(mk(1, 1, 1, 0, 0, 4'b1001, 1, 4'b0000, 1, 3'd2), "burst2");
        apply(mk(1, 1, 1, 0, 0, 4'b1110, 1, 4'b0011, 1, 3'd2), "burst3");
        apply(mk(1, 0, 0, 0, 0, 4'b0000, 1, 4'b0101, 1, 3'd2), "burst4");
        apply(mk(1, 0, 0, 0, 0, 4'b0000, 1, 4'b1001, 1, 3'd1), "burst5");
        apply(mk(1, 0, 0, 0, 0, 4'b0000, 1, 4'b1110, 0, 3'd0), "burst6");

        // Flush of a new instruction while older slots drain: slots commit.
        apply(mk(1, 1, 1, 0, 0, 4'b0111, 1, 4'b1110, 1, 3'd0), "drain0");
        apply(mk(1, 1, 1, 0, 1, 4'b1111, 1, 4'b1110, 1, 3'd1), "drain1");
        apply(mk(1, 0, 0, 0, 0, 4'b0000, 1, 4'b1110, 1, 3'd1), "drain2");
        apply(mk(1, 0, 0, 0, 0, 4'b0000, 1, 4'b0111, 0, 3'd0), "drain3");
`else
        // Forwarding build: EX flags appear immediately, no hazard.
        apply(mk(0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 3'd0), "fwd_rst");
        apply(mk(1, 0, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 3'd0), "fwd_idle");
        apply(mk(1, 1, 1, 0, 0, 4'b1001, 1, 4'b1001, 0, 3'd0), "fwd_ex");
        apply(mk(1, 0, 0, 0, 0, 4'b0000, 1, 4'b1001, 0, 3'd1), "fwd_slot0");
        apply(mk(1, 0, 0, 0, 0, 4'b0000, 1, 4'b1001, 0, 3'd1), "fwd_slot1");
        apply(mk(1, 0, 0, 0, 0, 4'b0000, 1, 4'b1001, 0, 3'd0), "fwd_sr");
        apply(mk(1, 1, 1, 1, 0, 4'b0110, 1, 4'b0110, 0, 3'd0), "fwd_stall");
        apply(mk(1, 1, 1, 0, 1, 4'b1111, 1, 4'b1001, 0, 3'd0), "fwd_flush");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
